fnn_dense_layer: RTL
====================

# fnn_dense_layer

Parametrised fully-connected layer for the FNN datapath. It generalises the fixed per-layer blocks into one module with configurable neuron count, fan-in and fixed-point widths. Weights and biases are held internally and the layer consumes a valid/ready input stream, with all neurons multiply-accumulating each input in parallel. After bias, scaling, activation and saturation it emits either every neuron value or a single argmax index on a valid/ready output stream with a `last` marker. Layers chain directly, output stream to input stream, with the final layer running in argmax mode.

## Interface
- `NN`, 10, neuron count (≥1)
- `PREV_COUNT`, 30, inputs per inference (fan-in, ≥1)
- `IN_WIDTH`, 26, signed input sample width
- `W_WIDTH`, 16, signed weight/bias width
- `W_FRAC`, 8, fractional bits of weights; products are arithmetically shifted right by this amount
- `NIDX_W`, 4, neuron-select width (≥clog2(NN))
- `AIDX_W`, 6, weight-address width (≥clog2(PREV_COUNT+1))
- `OUT_WIDTH`, derived = IN_WIDTH+3, signed output width
- `ACC_WIDTH`, derived = IN_WIDTH+W_WIDTH+clog2(PREV_COUNT)+1, accumulator width

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `wt_valid` in 1: weight write strobe
- `wt_ready` out 1: high only in IDLE
- `wt_neuron` in NIDX_W: target neuron
- `wt_addr` in AIDX_W: 0..PREV_COUNT-1 selects a weight; PREV_COUNT selects the bias
- `wt_data` in W_WIDTH: weight or bias value
- `wt_clear` in 1: clears all loaded flags (weights retained)
- `layer_ready` out 1: all neurons have their bias written
- `start` in 1: begin an inference
- `mode` in 2: 0 identity, 1 ReLU, 2 argmax, 3 behaves as 1; latched at start
- `abort` in 1: synchronous return to IDLE
- `in_valid`/`in_ready` in/out 1: input handshake
- `in_data` in IN_WIDTH: signed sample
- `out_valid`/`out_ready` out/in 1: output handshake
- `out_data` out OUT_WIDTH: neuron value, or argmax index zero-extended
- `out_last` out 1: marks the final output beat
- `busy` out 1: high whenever state ≠ IDLE
- `done` out 1: one-cycle pulse after the last output beat is accepted

## Operation
- Reset value of every output is 0. Reset clears accumulators, loaded flags and the PISO, and sets state to IDLE. Weight storage is not reset.
- **Weight write:** on `wt_valid && wt_ready`, write `mem[wt_neuron][wt_addr] <= wt_data`.
  - Writes with `wt_neuron ≥ NN` or `wt_addr > PREV_COUNT` are dropped.
  - A bias write (`wt_addr == PREV_COUNT`) sets `loaded[wt_neuron]`. The bias is written last.
  - `layer_ready = &loaded`.
  - `wt_clear` takes priority over a same-cycle bias write.
- **IDLE:** on `start && layer_ready`, latch `mode`, zero all accumulators and the input counter k, then go to ACCUM. `start` while `!layer_ready` is ignored.
- **ACCUM:** `in_ready = 1`. On each handshake, for every neuron n: `acc[n] += in_data * mem[n][k]` (full-precision signed), then k++. When the beat with k == PREV_COUNT-1 is accepted, go to ACT.
- **ACT (1 cycle):**
  - `v = (acc + sext(bias)) >>> W_FRAC`. The bias is at product scale.
  - Apply ReLU when mode is 1 or 3, so that v < 0 becomes 0.
  - Saturate to the OUT_WIDTH signed range.
  - Load the PISO with neuron 0 at the head.
  - Next state is ARGMAX if mode == 2, else SHIFT.
- **ARGMAX (NN cycles):** sequential scan of the activated values, one neuron per cycle. Keep the best value and its index; replace only on strictly greater, so ties resolve to the lowest index. Then go to SHIFT.
- **SHIFT:**
  - `out_valid = 1` and `out_data` = PISO head.
  - `out_last = 1` on the beat of neuron NN-1, or on the single argmax beat.
  - On each handshake, shift the PISO by OUT_WIDTH.
  - After the last handshake: `done` pulses, go to IDLE.
  - `out_data` is held stable while `out_valid && !out_ready`.
- **abort:** from any state, on the next edge go to IDLE with outputs deasserted. No `done` pulse; the partial accumulation is discarded. `abort` has priority over `start` and over all handshakes.

## Timing
- `in_ready` rises the cycle after `start` is sampled.
- Last input accepted at edge t, then ACT in cycle t+1.
- First `out_valid` in cycle t+2 (identity/ReLU) or t+2+NN (argmax).
- A back-to-back output stream with `out_ready = 1` takes NN cycles. `done` goes high the cycle after the final handshake, coincident with `busy = 0`.
- Input bubbles (`in_valid = 0`) only stall; they never advance k.
- A new `start` is accepted in the cycle `done` is high.

## Test plan
Bench parameters: NN=4, PREV_COUNT=3, W_FRAC=8. Inputs are 5, -7, 2.

1. **Identity.** Neuron weights/biases:
   - n0 = {256,256,256} / 0
   - n1 = {512,0,0} / 0
   - n2 = {-256,0,0} / 0
   - n3 = {0,256,0} / 2560

   Required response, with `out_ready = 1`: outputs 0, 10, -5, 3, `out_last` on the 4th beat, `done` one cycle later.
2. **ReLU**, same weights: outputs 0, 10, 0, 3.
3. **Argmax**, same weights: a single beat with `out_data = 1`, `out_last = 1`.
   - Change n3's bias to 4352 (n3 = 10): the index is still 1 (tie resolves low).
4. **Saturation.** Three inputs of 2^25-1, n0 weights all 32767: n0 = 268435455.
   - Negating the weights gives -268435456.
5. **Backpressure.** Hold `out_ready = 0` for 5 cycles mid-stream, and insert `in_valid` bubbles: `out_data` stays stable and the output sequence is unchanged.
6. **Abort, load gating and reset.**
   - `abort` after 2 inputs: IDLE, no `done`.
   - A rerun produces correct values.
   - `wt_clear` then `start`: ignored (`busy` stays 0).
   - Deasserting `rstn` mid-SHIFT: all outputs are 0 immediately.

Source files
------------

// File: rtl/fnn_dense_layer.sv
// Parametrised fully-connected layer: parallel per-neuron MACs over a valid/ready input stream,
// then bias/scale/activation/saturation, emitted as a neuron stream or a single argmax index.
module fnn_dense_layer #(
    parameter int unsigned NN         = 10,
    parameter int unsigned PREV_COUNT = 30,
    parameter int unsigned IN_WIDTH   = 26,
    parameter int unsigned W_WIDTH    = 16,
    parameter int unsigned W_FRAC     = 8,
    parameter int unsigned NIDX_W     = 4,
    parameter int unsigned AIDX_W     = 6,
    parameter int unsigned OUT_WIDTH  = IN_WIDTH + 3,
    parameter int unsigned ACC_WIDTH  = IN_WIDTH + W_WIDTH + $clog2(PREV_COUNT) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wt_valid,
    output logic                 wt_ready,
    input  logic [NIDX_W-1:0]    wt_neuron,
    input  logic [AIDX_W-1:0]    wt_addr,
    input  logic [W_WIDTH-1:0]   wt_data,
    input  logic                 wt_clear,
    output logic                 layer_ready,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned SW = ACC_WIDTH + 1;
    localparam int unsigned PW = IN_WIDTH + W_WIDTH;
    localparam logic signed [SW-1:0] SatMax = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SatMin = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAccum, StAct, StArgmax, StShift} state_e;

    state_e state_q, state_d;

    logic signed [W_WIDTH-1:0]   mem [NN][PREV_COUNT+1];
    logic [NN-1:0]               loaded_q;
    logic signed [ACC_WIDTH-1:0] acc_q [NN];
    logic [AIDX_W-1:0]           k_q;
    logic [1:0]                  mode_q;
    logic [OUT_WIDTH-1:0]        piso_q [NN];
    logic [NIDX_W-1:0]           cnt_q;  // argmax scan index, then output beat index
    logic signed [OUT_WIDTH-1:0] best_q;
    logic [NIDX_W-1:0]           best_idx_q;
    logic wt_ready_q, in_ready_q, out_valid_q, out_last_q, done_q;

    logic signed [W_WIDTH-1:0]   w_sel  [NN];
    logic signed [PW-1:0]        prod_v [NN];
    logic signed [SW-1:0]        sum_v  [NN];
    logic signed [SW-1:0]        sh_v   [NN];
    logic [OUT_WIDTH-1:0]        act_val [NN];
    logic signed [OUT_WIDTH-1:0] scan_val;
    logic                        arg_take;
    logic                        wt_hs;

    assign wt_hs = wt_valid && wt_ready_q;

    always_comb begin
        for (int n = 0; n < NN; n++) begin
            w_sel[n] = '0;
            for (int a = 0; a < PREV_COUNT; a++) begin
                if (k_q == AIDX_W'(a)) w_sel[n] = mem[n][a];
            end
            prod_v[n] = PW'($signed(in_data)) * PW'(w_sel[n]);
            // Bias is stored at product scale, so it joins the accumulator before the shift.
            sum_v[n]  = SW'(acc_q[n]) + SW'(mem[n][PREV_COUNT]);
            sh_v[n]   = sum_v[n] >>> W_FRAC;
            if (mode_q[0] && sh_v[n] < 0) sh_v[n] = '0;
            if (sh_v[n] > SatMax)      act_val[n] = OUT_WIDTH'(SatMax);
            else if (sh_v[n] < SatMin) act_val[n] = OUT_WIDTH'(SatMin);
            else                       act_val[n] = OUT_WIDTH'(sh_v[n]);
        end
    end

    always_comb begin
        scan_val = '0;
        for (int n = 0; n < NN; n++) begin
            if (cnt_q == NIDX_W'(n)) scan_val = piso_q[n];
        end
        // Strictly greater keeps the lowest index on ties.
        arg_take = (cnt_q == '0) || (scan_val > best_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start && layer_ready) state_d = StAccum;
            StAccum:  if (in_valid && k_q == AIDX_W'(PREV_COUNT - 1)) state_d = StAct;
            StAct:    state_d = (mode_q == 2'd2) ? StArgmax : StShift;
            StArgmax: if (cnt_q == NIDX_W'(NN - 1)) state_d = StShift;
            StShift:  if (out_ready && out_last_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (wt_hs) begin
            for (int n = 0; n < NN; n++) begin
                for (int a = 0; a <= PREV_COUNT; a++) begin
                    if (wt_neuron == NIDX_W'(n) && wt_addr == AIDX_W'(a)) mem[n][a] <= wt_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            loaded_q    <= '0;
            k_q         <= '0;
            mode_q      <= '0;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            wt_ready_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                acc_q[n]  <= '0;
                piso_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wt_ready_q  <= (state_d == StIdle);
            in_ready_q  <= (state_d == StAccum);
            out_valid_q <= (state_d == StShift);
            done_q      <= 1'b0;

            if (wt_clear) begin
                loaded_q <= '0;
            end else if (wt_hs && wt_addr == AIDX_W'(PREV_COUNT)) begin
                for (int n = 0; n < NN; n++) begin
                    if (wt_neuron == NIDX_W'(n)) loaded_q[n] <= 1'b1;
                end
            end

            if (abort) begin
                out_last_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && layer_ready) begin
                            mode_q <= mode;
                            k_q    <= '0;
                            for (int n = 0; n < NN; n++) acc_q[n] <= '0;
                        end
                    end
                    StAccum: begin
                        if (in_valid) begin
                            for (int n = 0; n < NN; n++) begin
                                acc_q[n] <= acc_q[n] + ACC_WIDTH'(prod_v[n]);
                            end
                            k_q <= k_q + 1'b1;
                        end
                    end
                    StAct: begin
                        for (int n = 0; n < NN; n++) piso_q[n] <= act_val[n];
                        cnt_q      <= '0;
                        out_last_q <= (NN == 1) && (mode_q != 2'd2);
                    end
                    StArgmax: begin
                        if (arg_take) begin
                            best_q     <= scan_val;
                            best_idx_q <= cnt_q;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == NIDX_W'(NN - 1)) begin
                            piso_q[0]  <= OUT_WIDTH'(arg_take ? cnt_q : best_idx_q);
                            cnt_q      <= '0;
                            out_last_q <= 1'b1;
                        end
                    end
                    StShift: begin
                        if (out_ready) begin
                            if (out_last_q) begin
                                out_last_q <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                for (int n = 0; n < NN - 1; n++) piso_q[n] <= piso_q[n+1];
                                piso_q[NN-1] <= '0;
                                cnt_q        <= cnt_q + 1'b1;
                                out_last_q   <= (cnt_q == NIDX_W'(NN - 2));
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wt_ready    = wt_ready_q;
    assign layer_ready = &loaded_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = piso_q[0];
    assign out_last    = out_last_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;

endmodule
